vis_marker_overlay: RTL and testbench

//  Multi-marker overlay for the video path. It draws up to N_MARKERS filled discs of radius RADIUS
//  on a 24-bit RGB stream, using a true Euclidean (squared-distance) test, and passes de/hsync/vsync

---
 rtl/vis_pkg.sv | 15 +
 rtl/vis_marker_overlay_if.sv | 11 +
 rtl/vis_marker_hit.sv | 55 +++++
 rtl/vis_marker_overlay.sv | 104 ++++++++++
 tb/tb_vis_marker_overlay.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vis_pkg.sv
// Shared widths, colour constants and helpers for the marker overlay datapath.
package vis_pkg;
    localparam int COORD_W = 11;
    localparam int PIX_W   = 24;
    localparam int D2_W    = 23;

    localparam logic [PIX_W-1:0] RGB_RED   = 24'hFF0000;
    localparam logic [PIX_W-1:0] RGB_GREEN = 24'h00FF00;
    localparam logic [PIX_W-1:0] RGB_BLACK = 24'h000000;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction
endpackage

// File: rtl/vis_marker_overlay_if.sv
// Video stream bundle: data enable, syncs and one RGB pixel per clock.
interface vis_marker_overlay_if;
    import vis_pkg::*;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic [PIX_W-1:0] pixel;

    modport master (output de, hsync, vsync, pixel);
    modport slave  (input  de, hsync, vsync, pixel);
endinterface

// File: rtl/vis_marker_hit.sv
// Per-marker disc test: |dx|,|dy| -> squared distance -> compare, hit valid at stage 3.
// VIS_MARKER_CROSS_EN adds a crosshair of half-length 2*RADIUS to the disc.
module vis_marker_hit
    import vis_pkg::*;
#(
    parameter int RADIUS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] i_x_pos,
    input  logic [COORD_W-1:0] i_y_pos,
    input  logic [COORD_W-1:0] i_mx,
    input  logic [COORD_W-1:0] i_my,
    input  logic               i_valid,
    input  logic               i_de,
    output logic               o_hit
);
    localparam logic [D2_W-1:0] THR = D2_W'(RADIUS * RADIUS);

    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic [D2_W-1:0]    r_d2;
    logic [D2_W-1:0]    w_d2;

    assign w_d2 = D2_W'(r_dx) * D2_W'(r_dx) + D2_W'(r_dy) * D2_W'(r_dy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx <= '0;
            r_dy <= '0;
            r_d2 <= '0;
        end else begin
            r_dx <= abs_diff(i_x_pos, i_mx);
            r_dy <= abs_diff(i_y_pos, i_my);
            r_d2 <= w_d2;
        end
    end

`ifdef VIS_MARKER_CROSS_EN
    localparam logic [COORD_W-1:0] ARM = COORD_W'(2 * RADIUS);
    logic r_cross;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cross <= 1'b0;
        end else begin
            r_cross <= ((r_dx == '0) && (r_dy <= ARM)) || ((r_dy == '0) && (r_dx <= ARM));
        end
    end

    assign o_hit = i_valid & i_de & ((r_d2 <= THR) | r_cross);
`else
    assign o_hit = i_valid & i_de & (r_d2 <= THR);
`endif
endmodule

// File: rtl/vis_marker_overlay.sv
// Multi-marker disc overlay on an RGB stream, 3-cycle latency with aligned de/hsync/vsync.
// Optional crosshair drawing is enabled by defining VIS_MARKER_CROSS_EN.
module vis_marker_overlay
    import vis_pkg::*;
#(
    parameter int               IMG_W     = 1280,
    parameter int               IMG_H     = 720,
    parameter int               N_MARKERS = 4,
    parameter int               RADIUS    = 4,
    parameter logic [PIX_W-1:0] COLOR     = RGB_RED
) (
    input  logic                           clk,
    input  logic                           rst,
    vis_marker_overlay_if.slave            i_vid,
    vis_marker_overlay_if.master           o_vid,
    input  logic [COORD_W*N_MARKERS-1:0]   i_marker_x,
    input  logic [COORD_W*N_MARKERS-1:0]   i_marker_y,
    input  logic [N_MARKERS-1:0]           i_marker_valid
);
    logic [COORD_W-1:0]           r_x_pos;
    logic [COORD_W-1:0]           r_y_pos;
    logic [2:0]                   r_de_d;
    logic [2:0]                   r_hs_d;
    logic [2:0]                   r_vs_d;
    logic [PIX_W-1:0]             r_pix_d0;
    logic [PIX_W-1:0]             r_pix_d1;
    logic [PIX_W-1:0]             r_pix_out;
    logic [COORD_W*N_MARKERS-1:0] r_sh_x;
    logic [COORD_W*N_MARKERS-1:0] r_sh_y;
    logic [N_MARKERS-1:0]         r_sh_v;
    logic [N_MARKERS-1:0]         w_hit;
    logic                         w_vs_rise;

    // r_vs_d[0] doubles as the previous-cycle vsync for edge detection
    assign w_vs_rise = i_vid.vsync & ~r_vs_d[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_pos <= '0;
            r_y_pos <= '0;
        end else if (i_vid.vsync) begin
            r_x_pos <= '0;
            r_y_pos <= '0;
        end else if (i_vid.de) begin
            if (r_x_pos == COORD_W'(IMG_W - 1)) begin
                r_x_pos <= '0;
                r_y_pos <= (r_y_pos == COORD_W'(IMG_H - 1)) ? '0 : r_y_pos + 1'b1;
            end else begin
                r_x_pos <= r_x_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_x <= '0;
            r_sh_y <= '0;
            r_sh_v <= '0;
        end else if (w_vs_rise) begin
            r_sh_x <= i_marker_x;
            r_sh_y <= i_marker_y;
            r_sh_v <= i_marker_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de_d    <= '0;
            r_hs_d    <= '0;
            r_vs_d    <= '0;
            r_pix_d0  <= '0;
            r_pix_d1  <= '0;
            r_pix_out <= '0;
        end else begin
            r_de_d    <= {r_de_d[1:0], i_vid.de};
            r_hs_d    <= {r_hs_d[1:0], i_vid.hsync};
            r_vs_d    <= {r_vs_d[1:0], i_vid.vsync};
            r_pix_d0  <= i_vid.pixel;
            r_pix_d1  <= r_pix_d0;
            r_pix_out <= (|w_hit) ? COLOR : r_pix_d1;
        end
    end

    for (genvar g = 0; g < N_MARKERS; g++) begin : g_hit
        vis_marker_hit #(
            .RADIUS (RADIUS)
        ) u_hit (
            .clk     (clk),
            .rst     (rst),
            .i_x_pos (r_x_pos),
            .i_y_pos (r_y_pos),
            .i_mx    (r_sh_x[COORD_W*g +: COORD_W]),
            .i_my    (r_sh_y[COORD_W*g +: COORD_W]),
            .i_valid (r_sh_v[g]),
            .i_de    (r_de_d[1]),
            .o_hit   (w_hit[g])
        );
    end

    assign o_vid.de    = r_de_d[2];
    assign o_vid.hsync = r_hs_d[2];
    assign o_vid.vsync = r_vs_d[2];
    assign o_vid.pixel = r_pix_out;
endmodule

// File: tb/tb_vis_marker_overlay.sv
// Randomised and directed bench for vis_marker_overlay on a 64x32 frame with a geometric reference model.
module tb_vis_marker_overlay;
    localparam int W = 64;
    localparam int H = 32;
    localparam int N = 4;
    localparam int R = 4;
    localparam logic [23:0] COL = 24'hFF0000;

    logic clk;
    logic rst;
    logic [11*N-1:0] mk_x;
    logic [11*N-1:0] mk_y;
    logic [N-1:0]    mk_v;

    vis_marker_overlay_if vin ();
    vis_marker_overlay_if vout ();

    vis_marker_overlay #(
        .IMG_W     (W),
        .IMG_H     (H),
        .N_MARKERS (N),
        .RADIUS    (R),
        .COLOR     (COL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_vid          (vin),
        .o_vid          (vout),
        .i_marker_x     (mk_x),
        .i_marker_y     (mk_y),
        .i_marker_valid (mk_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // marker inputs currently driven, and values to switch to mid-frame
    int mx[N], my[N];
    bit mv[N];
    int nx[N], ny[N];
    bit nv[N];

    // reference model state
    int xm, ym;
    bit vs_prev;
    int sh_x[N], sh_y[N];
    bit sh_v[N];
    logic [26:0] exp_q[$];

    // observed output frame map
    bit map[H][W];
    int ox, oy;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit in_shape(int x, int y, int cx, int cy);
        int dx, dy;
        dx = x - cx;
        dy = y - cy;
        if (dx * dx + dy * dy <= R * R) return 1'b1;
`ifdef VIS_MARKER_CROSS_EN
        if ((dx == 0 && iabs(dy) <= 2 * R) || (dy == 0 && iabs(dx) <= 2 * R)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit in_mark(int x, int y);
        for (int i = 0; i < N; i++)
            if (sh_v[i] && in_shape(x, y, sh_x[i], sh_y[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int shape_count(int cx, int cy);
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (in_shape(x, y, cx, cy)) c++;
        return c;
    endfunction

    function automatic int map_count();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (map[y][x]) c++;
        return c;
    endfunction

    function automatic logic [23:0] rp();
        logic [23:0] v;
        v = 24'($urandom());
        v[0] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, int obs, int expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_map();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                map[y][x] = 1'b0;
    endtask

    task automatic step(bit r, bit de, bit hs, bit vs, logic [23:0] pix);
        logic [26:0] e;
        logic [26:0] o;
        @(negedge clk);
        o = {vout.de, vout.hsync, vout.vsync, vout.pixel};
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            checks++;
            assert (o === e)
            else begin
                errors++;
                $error("FAIL pipe observed=%h expected=%h", o, e);
            end
        end
        if (vout.vsync === 1'b1) begin
            ox = 0;
            oy = 0;
        end else if (vout.de === 1'b1) begin
            if (oy < H && ox < W) map[oy][ox] = (vout.pixel === COL);
            ox++;
            if (ox == W) begin
                ox = 0;
                oy++;
            end
        end
        rst = r;
        vin.de = de;
        vin.hsync = hs;
        vin.vsync = vs;
        vin.pixel = pix;
        for (int i = 0; i < N; i++) begin
            mk_x[11*i +: 11] = 11'(mx[i]);
            mk_y[11*i +: 11] = 11'(my[i]);
            mk_v[i] = mv[i];
        end
        if (r) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(27'd0);
            xm = 0;
            ym = 0;
            vs_prev = 1'b0;
            for (int i = 0; i < N; i++) sh_v[i] = 1'b0;
        end else begin
            exp_q.push_back({de, hs, vs, (de && in_mark(xm, ym)) ? COL : pix});
            if (vs && !vs_prev)
                for (int i = 0; i < N; i++) begin
                    sh_x[i] = mx[i];
                    sh_y[i] = my[i];
                    sh_v[i] = mv[i];
                end
            vs_prev = vs;
            if (vs) begin
                xm = 0;
                ym = 0;
            end else if (de) begin
                if (xm == W - 1) begin
                    xm = 0;
                    ym = (ym == H - 1) ? 0 : ym + 1;
                end else begin
                    xm++;
                end
            end
        end
    endtask

    task automatic run_line();
        for (int c = 0; c < W; c++) step(0, 1, 0, 0, rp());
        for (int c = 0; c < 8; c++) step(0, 0, (c >= 2 && c < 6), 0, rp());
    endtask

    // chg_line < 0 means the marker inputs stay constant for the frame
    task automatic run_frame(int chg_line);
        clear_map();
        for (int c = 0; c < 6; c++) step(0, 0, 0, 1, rp());
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, rp());
        for (int l = 0; l < H; l++) begin
            if (l == chg_line)
                for (int i = 0; i < N; i++) begin
                    mx[i] = nx[i];
                    my[i] = ny[i];
                    mv[i] = nv[i];
                end
            run_line();
        end
        for (int c = 0; c < 6; c++) step(0, 0, 0, 0, rp());
    endtask

    task automatic set_one(int i, int x, int y, bit v);
        mx[i] = x;
        my[i] = y;
        mv[i] = v;
    endtask

    initial begin
        rst = 1'b1;
        vin.de = 1'b0;
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        vin.pixel = '0;
        mk_x = '0;
        mk_y = '0;
        mk_v = '0;
        ox = 0;
        oy = 0;
        for (int i = 0; i < N; i++) set_one(i, 0, 0, 1'b0);

        // reset held while a frame is being driven
        set_one(0, 2, 0, 1'b1);
        step(1, 0, 0, 1, rp());
        step(1, 1, 0, 0, rp());
        step(1, 1, 1, 1, rp());
        step(1, 1, 0, 0, rp());
        chk("rst_pixel", int'(vout.pixel), 0);
        chk("rst_ctrl", int'({vout.de, vout.hsync, vout.vsync}), 0);

        // no drawing before the first vsync rise
        clear_map();
        for (int l = 0; l < 3; l++) run_line();
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, rp());
        chk("pre_vsync_none", map_count(), 0);

        // single disc
        set_one(0, 20, 10, 1'b1);
        run_frame(-1);
`ifdef VIS_MARKER_CROSS_EN
        chk("disc_count", map_count(), 65);
`else
        chk("disc_count", map_count(), 49);
`endif
        chk("disc_hit_24_10", int'(map[10][24]), 1);
        chk("disc_miss_23_13", int'(map[13][23]), 0);
        chk("disc_center", int'(map[10][20]), 1);

        // edge clip at the origin
        set_one(0, 0, 0, 1'b1);
        run_frame(-1);
        chk("clip_count", map_count(), shape_count(0, 0));
        begin
            int c63 = 0;
            for (int y = 0; y < H; y++) if (map[y][W-1]) c63++;
            chk("clip_no_wrap", c63, 0);
        end

        // frame latch: inputs change mid-frame
        set_one(0, 20, 10, 1'b1);
        for (int i = 0; i < N; i++) begin
            nx[i] = mx[i];
            ny[i] = my[i];
            nv[i] = mv[i];
        end
        nx[0] = 40;
        ny[0] = 20;
        run_frame(5);
        chk("latch_old_drawn", int'(map[10][20]), 1);
        chk("latch_new_absent", int'(map[20][40]), 0);
        run_frame(-1);
        chk("latch_new_drawn", int'(map[20][40]), 1);
        chk("latch_old_gone", int'(map[10][20]), 0);

        // per-channel valid
        set_one(0, 10, 5, 1'b0);
        set_one(1, 10, 5, 1'b1);
        set_one(2, 50, 25, 1'b0);
        set_one(3, 30, 20, 1'b1);
        run_frame(-1);
        chk("valid_m1", int'(map[5][10]), 1);
        chk("valid_m3", int'(map[20][30]), 1);
        chk("invalid_m2", int'(map[25][50]), 0);

        // crosshair probe points
        for (int i = 0; i < N; i++) set_one(i, 0, 0, 1'b0);
        set_one(0, 30, 15, 1'b1);
        run_frame(-1);
`ifdef VIS_MARKER_CROSS_EN
        chk("cross_38_15", int'(map[15][38]), 1);
        chk("cross_30_7", int'(map[7][30]), 1);
`else
        chk("cross_38_15", int'(map[15][38]), 0);
        chk("cross_30_7", int'(map[7][30]), 0);
`endif
        chk("cross_38_16", int'(map[16][38]), 0);

        // randomised markers, some outside the frame, some changing mid-frame
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) begin
                set_one(i, $urandom_range(0, 70), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
                nx[i] = (f == 2) ? $urandom_range(0, 2047) : $urandom_range(0, 70);
                ny[i] = $urandom_range(0, 40);
                nv[i] = 1'($urandom_range(0, 1));
            end
            run_frame($urandom_range(0, H - 1));
        end

        // reset mid-frame, then realignment on the next vsync
        for (int i = 0; i < N; i++) set_one(i, 0, 0, 1'b0);
        set_one(2, 33, 16, 1'b1);
        for (int c = 0; c < 6; c++) step(0, 0, 0, 1, rp());
        for (int l = 0; l < 4; l++) run_line();
        for (int c = 0; c < 10; c++) step(0, 1, 0, 0, rp());
        step(1, 1, 0, 0, rp());
        step(1, 1, 0, 0, rp());
        for (int c = 0; c < 20; c++) step(0, 1, 0, 0, rp());
        for (int l = 0; l < 2; l++) run_line();
        for (int c = 0; c < 6; c++) step(0, 0, 0, 0, rp());
        run_frame(-1);
        chk("realign_count", map_count(), shape_count(33, 16));
        chk("realign_center", int'(map[16][33]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
